spi_fifo_bridge: RTL and testbench
==================================

Name: spi_fifo_bridge

Overview:
- Upstream/host-side companion to spi_master; sits between a host bus and spi_master's byte handshake (tx_data/tx_valid/tx_ready/rx_data).
- Buffers outgoing bytes in a TX FIFO and issues them one at a time to spi_master.
- Captures each received byte into an RX FIFO.
- Adds stall-on-RX-full flow control and a hang timeout, so the host can stream bursts without polling per byte.

Parameters:
- DATA_WIDTH, 8, byte width; must match spi_master DATA_WIDTH.
- FIFO_DEPTH, 16, entries per FIFO; power of two, >=2.
- TIMEOUT_CYC, 4096, max clk cycles one transfer may take before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_data  in  DATA_WIDTH  host byte to transmit.
- wr_en  in  1  push wr_data into TX FIFO.
- tx_full  out  1  TX FIFO full.
- tx_level  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy.
- rd_en  in  1  pop RX FIFO head.
- rd_data  out  DATA_WIDTH  RX FIFO head; first-word fall-through, valid when !rx_empty.
- rx_empty  out  1  RX FIFO empty.
- rx_level  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
- busy  out  1  high whenever FSM is not IDLE.
- err_timeout  out  1  sticky; transfer aborted on timeout.
- err_txdrop  out  1  sticky; wr_en while tx_full.
- err_clr  in  1  clears both sticky errors.
- m_tx_data  out  DATA_WIDTH  to spi_master tx_data.
- m_tx_valid  out  1  to spi_master tx_valid; single-cycle pulse.
- m_tx_ready  in  1  from spi_master tx_ready; high means idle/done.
- m_rx_data  in  DATA_WIDTH  from spi_master rx_data; valid once m_tx_ready re-rises.

Behaviour:
- Reset (rst=1 at clk edge):
  - FIFOs emptied; tx_level=rx_level=0; tx_full=0; rx_empty=1.
  - m_tx_valid=0, m_tx_data=0, busy=0, both errors=0; FSM=IDLE.
  - Applies mid-transfer too: the in-flight byte is lost. The system also holds spi_master in reset (rst_n = ~rst).
- FIFO rules:
  - A write is accepted iff tx_full was 0 at the start of the cycle. A write while full is dropped and sets err_txdrop, even if a pop happens in the same cycle.
  - A read on empty is ignored.
  - Simultaneous push and pop on the same FIFO leaves its level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; the level counter distinguishes full from empty.
- FSM:
  - IDLE: if TX non-empty AND rx_level<FIFO_DEPTH AND m_tx_ready=1 -> pop TX head into m_tx_data, m_tx_valid=1 for exactly this cycle, go to WAIT_BUSY, clear timeout counter. If RX is full, stay in IDLE (stall; never drop RX data).
  - WAIT_BUSY: wait for m_tx_ready=0 -> WAIT_DONE.
  - WAIT_DONE: wait for m_tx_ready=1 -> CAPTURE.
  - CAPTURE: push m_rx_data into RX FIFO (one cycle) -> IDLE.
  - Timeout: in WAIT_BUSY/WAIT_DONE the counter increments every cycle. When it reaches TIMEOUT_CYC-1: set err_timeout, no RX push, go to IDLE.
- Latency:
  - wr_en at cycle N (FIFO empty, idle master) -> m_tx_valid high at N+2.
  - Master done (m_tx_ready rises) at cycle M -> rx_empty falls at M+2.
  - Minimum inter-transfer gap: IDLE re-issues the cycle after CAPTURE.
- Since only one byte is ever in flight and it is reserved at issue, an RX push never overflows.
- err_clr and a new error event in the same cycle: the error wins (stays set).
- m_tx_data holds its value until the next issue.

Decomposition:
- Package spi_pkg:
  - FSM state enum (IDLE, WAIT_BUSY, WAIT_DONE, CAPTURE).
  - Default DATA_WIDTH/FIFO_DEPTH constants.
  - A level-width function.
- One sub-module, spi_sync_fifo (parameterised width/depth, FWFT, level output), instantiated twice (TX, RX).
- FSM and timeout logic stay in the top level.

Test Plan:
- Single byte: push 0xA5, spi_master clk_div=4, loopback slave returning ~MOSI. Required: exactly one m_tx_valid pulse with m_tx_data=0xA5; after completion rx_level=1, rd_data=0x5A; busy returns to 0.
- Burst: push 0x01..0x10 (16 bytes). Required: tx_full=1 after 16th write; a 17th write (0xFF) is dropped and err_txdrop=1; RX receives 0xFE..0xEF in order.
- RX-full stall: FIFO_DEPTH=4, push 6 bytes, never read. Required: after 4 transfers rx_level=4, FSM stays IDLE, tx_level=2, no m_tx_valid. One rd_en -> exactly one more transfer issues.
- Timeout: TIMEOUT_CYC=64, force m_tx_ready stuck high after issue. Required: err_timeout=1 about 64 cycles after the pulse, rx_level unchanged, FSM IDLE; err_clr clears it.
- Reset mid-transfer: assert rst during WAIT_DONE with 3 bytes queued. Required: next cycle tx_level=0, rx_empty=1, busy=0, m_tx_valid=0; a fresh push 0x3C then transfers normally.
- Simultaneous push/pop: with tx_level=3 and RX non-empty, wr_en and rd_en in the same cycle as an FSM issue. Required: levels change by the exact net count, with no data loss or duplication.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI FIFO bridge
package spi_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_CAPTURE
  } state_e;

  // Level counters need one extra bit so a full FIFO is distinct from an empty one.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_fifo_bridge_if.sv
// rtl/spi_fifo_bridge_if.sv - byte handshake between the bridge and spi_master
interface spi_fifo_bridge_if #(
  parameter int DATA_WIDTH = spi_pkg::DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] m_tx_data;
  logic                  m_tx_valid;
  logic                  m_tx_ready;
  logic [DATA_WIDTH-1:0] m_rx_data;

  modport master (
    output m_tx_data,
    output m_tx_valid,
    input  m_tx_ready,
    input  m_rx_data
  );

  modport slave (
    input  m_tx_data,
    input  m_tx_valid,
    output m_tx_ready,
    output m_rx_data
  );

endinterface

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - synchronous first-word-fall-through FIFO with occupancy output
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [lvl_w(DEPTH)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  // Acceptance looks only at the state at the start of the cycle, so a push
  // while full is refused even if a pop frees a slot in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/spi_fifo_bridge.sv
// rtl/spi_fifo_bridge.sv - host TX/RX FIFOs feeding spi_master one byte at a time
// with RX-full stall and a per-transfer hang timeout.
module spi_fifo_bridge
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  input  logic                         wr_en_i,
  output logic                         tx_full_o,
  output logic [lvl_w(FIFO_DEPTH)-1:0] tx_level_o,
  input  logic                         rd_en_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic                         rx_empty_o,
  output logic [lvl_w(FIFO_DEPTH)-1:0] rx_level_o,
  output logic                         busy_o,
  output logic                         err_timeout_o,
  output logic                         err_txdrop_o,
  input  logic                         err_clr_i,
  spi_fifo_bridge_if.master            m_if
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  state_e                state_q, state_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_to_q, err_to_d;
  logic                  err_drop_q, err_drop_d;

  logic [DATA_WIDTH-1:0] tx_head;
  logic                  tx_empty, tx_full, tx_pop;
  logic                  rx_full, rx_push;
  logic                  to_set, drop_set;

  spi_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_en_i),
    .data_i  (wr_data_i),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level_o)
  );

  spi_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .data_i  (m_if.m_rx_data),
    .pop_i   (rd_en_i),
    .data_o  (rd_data_o),
    .full_o  (rx_full),
    .empty_o (rx_empty_o),
    .level_o (rx_level_o)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    data_d  = data_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    to_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only issue when RX has room, so the returning byte always fits.
        if (!tx_empty && !rx_full && m_if.m_tx_ready) begin
          tx_pop  = 1'b1;
          valid_d = 1'b1;
          data_d  = tx_head;
          cnt_d   = '0;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == TMAX) begin
          to_set  = 1'b1;
          state_d = ST_IDLE;
        end else if (!m_if.m_tx_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == TMAX) begin
          to_set  = 1'b1;
          state_d = ST_IDLE;
        end else if (m_if.m_tx_ready) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        rx_push = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new error event in the same cycle as err_clr keeps the flag set.
  assign drop_set   = wr_en_i && tx_full;
  assign err_to_d   = to_set   | (err_to_q   & ~err_clr_i);
  assign err_drop_d = drop_set | (err_drop_q & ~err_clr_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      err_to_q   <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      err_to_q   <= err_to_d;
      err_drop_q <= err_drop_d;
    end
  end

  assign m_if.m_tx_valid = valid_q;
  assign m_if.m_tx_data  = data_q;
  assign tx_full_o       = tx_full;
  assign busy_o          = (state_q != ST_IDLE);
  assign err_timeout_o   = err_to_q;
  assign err_txdrop_o    = err_drop_q;

endmodule

// File: tb/tb_spi_fifo_bridge.sv
// tb/tb_spi_fifo_bridge.sv - scoreboard bench for spi_fifo_bridge with a behavioural
// spi_master that loops back the inverted transmit byte.
module tb_spi_fifo_bridge;

  localparam int XFER = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic       tx_full, rx_empty, busy, err_timeout, err_txdrop;
  logic [4:0] tx_level, rx_level;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_count = 0;
  int valid_edge = 0;
  int done_edge = 0;
  bit stuck = 1'b0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  spi_fifo_bridge_if #(.DATA_WIDTH(8)) m_if ();

  spi_fifo_bridge #(
    .DATA_WIDTH  (8),
    .FIFO_DEPTH  (16),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_data_i     (wr_data),
    .wr_en_i       (wr_en),
    .tx_full_o     (tx_full),
    .tx_level_o    (tx_level),
    .rd_en_i       (rd_en),
    .rd_data_o     (rd_data),
    .rx_empty_o    (rx_empty),
    .rx_level_o    (rx_level),
    .busy_o        (busy),
    .err_timeout_o (err_timeout),
    .err_txdrop_o  (err_txdrop),
    .err_clr_i     (err_clr),
    .m_if          (m_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue monitor: each valid pulse must carry the next expected TX byte.
  always @(negedge clk) begin
    if (!rst && m_if.m_tx_valid) begin
      tx_count++;
      valid_edge = cyc + 1;
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got data %0h with nothing queued", m_if.m_tx_data);
      end else begin
        chk("tx_data", 32'(m_if.m_tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  // Read monitor: each accepted pop must present the next expected RX byte.
  always @(negedge clk) begin
    if (!rst && rd_en && !rx_empty) begin
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rx: got %0h with nothing expected", rd_data);
      end else begin
        chk("rx_data", 32'(rd_data), 32'(exp_rx.pop_front()));
      end
    end
  end

  // Behavioural spi_master: busy for XFER cycles, returns ~MOSI byte.
  logic [7:0] mdata;
  always begin
    @(negedge clk);
    if (m_if.m_tx_valid && !stuck && !rst) begin
      mdata = m_if.m_tx_data;
      @(posedge clk);
      #1 m_if.m_tx_ready = 1'b0;
      for (int i = 0; i < XFER; i++) begin
        @(posedge clk);
        if (rst) break;
      end
      #1;
      m_if.m_rx_data  = ~mdata;
      m_if.m_tx_ready = 1'b1;
      done_edge = cyc + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: expected to be dropped, 1: full round trip, 2: issued but never returned
  task automatic push(input logic [7:0] b, input int mode);
    if (mode >= 1) exp_tx.push_back(b);
    if (mode == 1) exp_rx.push_back(~b);
    wr_data = b;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic readall();
    int n;
    n = 0;
    while (!rx_empty && n < 40) begin
      rd();
      n++;
    end
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || tx_level != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain_done"}, 32'(n < 600), 1);
  endtask

  initial begin
    int wr_edge, rx_edge, n, t0, rl;
    m_if.m_tx_ready = 1'b1;
    m_if.m_rx_data  = '0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_tx_level", 32'(tx_level), 0);
    chk("rst_rx_level", 32'(rx_level), 0);
    chk("rst_tx_full", 32'(tx_full), 0);
    chk("rst_rx_empty", 32'(rx_empty), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(m_if.m_tx_valid), 0);
    chk("rst_tx_data", 32'(m_if.m_tx_data), 0);
    chk("rst_errs", {30'd0, err_timeout, err_txdrop}, 0);

    // Single byte with latency
    wr_edge = cyc + 1;
    push(8'hA5, 1);
    n = 0;
    while (rx_empty && n < 100) begin
      @(negedge clk);
      n++;
    end
    rx_edge = cyc + 1;
    chk("single_rx_seen", 32'(n < 100), 1);
    chk("issue_latency", 32'(valid_edge - wr_edge), 2);
    chk("rx_latency", 32'(rx_edge - done_edge), 2);
    wait_drain("single");
    chk("single_pulses", 32'(tx_count), 1);
    chk("single_rx_level", 32'(rx_level), 1);
    chk("single_rd_data", 32'(rd_data), 'h5A);
    chk("single_busy", 32'(busy), 0);
    readall();

    // Burst with master held busy so TX fills
    tick();
    m_if.m_tx_ready = 1'b0;
    for (int i = 1; i <= 16; i++) push(8'(i), 1);
    chk("burst_tx_full", 32'(tx_full), 1);
    chk("burst_tx_level", 32'(tx_level), 16);
    push(8'hFF, 0);
    chk("burst_txdrop", 32'(err_txdrop), 1);
    chk("burst_level_after_drop", 32'(tx_level), 16);
    err_clr = 1'b1;
    push(8'hEE, 0);
    err_clr = 1'b0;
    chk("clr_vs_new_drop", 32'(err_txdrop), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("txdrop_cleared", 32'(err_txdrop), 0);
    m_if.m_tx_ready = 1'b1;
    wait_drain("burst");
    chk("burst_rx_level", 32'(rx_level), 16);

    // RX full stall
    t0 = tx_count;
    push(8'h21, 1);
    push(8'h22, 1);
    repeat (40) tick();
    chk("stall_tx_level", 32'(tx_level), 2);
    chk("stall_busy", 32'(busy), 0);
    chk("stall_no_issue", 32'(tx_count - t0), 0);
    chk("stall_rx_level", 32'(rx_level), 16);
    rd();
    repeat (40) tick();
    chk("unstall_one_issue", 32'(tx_count - t0), 1);
    chk("unstall_tx_level", 32'(tx_level), 1);
    chk("unstall_rx_level", 32'(rx_level), 16);
    readall();
    wait_drain("unstall");
    readall();

    // Simultaneous push/pop in the issue cycle
    push(8'h30, 1);
    wait_drain("pre_simul");
    tick();
    m_if.m_tx_ready = 1'b0;
    push(8'h31, 1);
    push(8'h32, 1);
    push(8'h33, 1);
    chk("simul_pre_tx", 32'(tx_level), 3);
    chk("simul_pre_rx", 32'(rx_level), 1);
    exp_tx.push_back(8'h34);
    exp_rx.push_back(8'hCB);
    wr_data = 8'h34;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    m_if.m_tx_ready = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("simul_tx_level", 32'(tx_level), 3);
    chk("simul_rx_level", 32'(rx_level), 0);
    chk("simul_busy", 32'(busy), 1);
    wait_drain("simul");
    chk("simul_final_rx", 32'(rx_level), 4);
    readall();

    // Timeout with master stuck ready
    stuck = 1'b1;
    rl = 32'(rx_level);
    push(8'h77, 2);
    n = 0;
    while (!err_timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_seen", 32'(n < 200), 1);
    chk("timeout_delay", 32'((cyc + 1) - valid_edge), 64);
    chk("timeout_rx_level", 32'(rx_level), 32'(rl));
    chk("timeout_busy", 32'(busy), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("timeout_cleared", 32'(err_timeout), 0);
    stuck = 1'b0;

    // Reset during WAIT_DONE
    push(8'h41, 1);
    push(8'h42, 1);
    push(8'h43, 1);
    n = 0;
    while (m_if.m_tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) tick();
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_tx_level", 32'(tx_level), 0);
    chk("mid_rst_rx_empty", 32'(rx_empty), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(m_if.m_tx_valid), 0);
    exp_tx.delete();
    exp_rx.delete();
    tick();
    push(8'h3C, 1);
    wait_drain("post_rst");
    chk("post_rst_rx_level", 32'(rx_level), 1);
    chk("post_rst_rd_data", 32'(rd_data), 'hC3);
    readall();

    tick();
    chk("exp_tx_empty", 32'(exp_tx.size()), 0);
    chk("exp_rx_empty", 32'(exp_rx.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
